// File: rtl/axi_lite_regfile_param.sv
// Parametrised AXI-Lite slave register file with byte strobes, read-only registers,
// SLVERR decode for out-of-range/RO accesses and independent AW/W acceptance.
module axi_lite_regfile_param #(
    parameter int                  ADDR_W   = 8,
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       awvalid,
    output logic                       awready,
    input  logic [ADDR_W-1:0]          awaddr,

    input  logic                       wvalid,
    output logic                       wready,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/8-1:0]        wstrb,

    output logic                       bvalid,
    input  logic                       bready,
    output logic [1:0]                 bresp,

    input  logic                       arvalid,
    output logic                       arready,
    input  logic [ADDR_W-1:0]          araddr,

    output logic                       rvalid,
    input  logic                       rready,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,

    output logic [NUM_REGS*DATA_W-1:0] reg_q
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Readies stay low until the first clock edge after reset is released.
    logic              ready_en;

    logic              aw_held;
    logic [ADDR_W-1:0] aw_addr_q;
    logic              w_held;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              commit;

    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_ok;

    logic [IDX_W-1:0]  rd_idx;
    logic              rd_in_range;

    // An address is in range when every bit above the register index is zero.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] upper;
        upper = addr >> (LSB + IDX_W);
        return (upper == '0);
    endfunction

    assign awready = ready_en && !aw_held && !bvalid;
    assign wready  = ready_en && !w_held  && !bvalid;
    assign arready = ready_en && !rvalid;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid  && wready;
    assign ar_hs  = arvalid && arready;
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);

    always_comb begin
        // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
        wr_addr     = aw_held ? aw_addr_q : awaddr;
        wr_data     = w_held  ? w_data_q  : wdata;
        wr_strb     = w_held  ? w_strb_q  : wstrb;
        wr_idx      = wr_addr[LSB +: IDX_W];
        wr_ok       = addr_in_range(wr_addr) && !RO_MASK[wr_idx];
        rd_idx      = araddr[LSB +: IDX_W];
        rd_in_range = addr_in_range(araddr);
    end

    // NOTE: sequential state is only ever written with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held   <= 1'b0;
            aw_addr_q <= '0;
        end else if (commit) begin
            aw_held   <= 1'b0;
        end else if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= awaddr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (commit) begin
            w_held   <= 1'b0;
        end else if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
        end
    end

    // NOTE: the register array is reset because its contents are exported on reg_q; it maps to flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && wr_ok) begin
            for (int j = 0; j < STRB_W; j++) begin
                if (wr_strb[j]) begin
                    regs[wr_idx][j*8 +: 8] <= wr_data[j*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
        end else if (commit) begin
            bvalid <= 1'b1;
            bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid && bready) begin
            bvalid <= 1'b0;
        end
    end

    // The read samples regs before this edge's write lands, so a colliding read sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_in_range ? regs[rd_idx] : '0;
            rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_axi_lite_regfile_param.sv
// Directed, table-driven bench for axi_lite_regfile_param (32-bit data, 16 regs, reg 0 read-only).
module tb_axi_lite_regfile_param;

    logic         clk;
    logic         rst_n;
    logic         awvalid;
    logic         awready;
    logic [7:0]   awaddr;
    logic         wvalid;
    logic         wready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         bvalid;
    logic         bready;
    logic [1:0]   bresp;
    logic         arvalid;
    logic         arready;
    logic [7:0]   araddr;
    logic         rvalid;
    logic         rready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic [511:0] reg_q;

    int checks = 0;
    int errors = 0;

    axi_lite_regfile_param #(
        .ADDR_W  (8),
        .DATA_W  (32),
        .NUM_REGS(16),
        .RO_MASK (16'h0001)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .awvalid(awvalid),
        .awready(awready),
        .awaddr (awaddr),
        .wvalid (wvalid),
        .wready (wready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .bvalid (bvalid),
        .bready (bready),
        .bresp  (bresp),
        .arvalid(arvalid),
        .arready(arready),
        .araddr (araddr),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata),
        .rresp  (rresp),
        .reg_q  (reg_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    localparam int NV = 21;
    vec_t vec [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return reg_q[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int   n;
        logic aw_fire;
        logic w_fire;
        bready  = 1'b1;
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            tick();
            if (aw_fire) awvalid = 1'b0;
            if (w_fire)  wvalid  = 1'b0;
            n++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        check("write_bvalid_seen", bvalid, 1'b1);
        resp = bresp;
        tick();
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        rready  = 1'b1;
        araddr  = a;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        check("read_rvalid_seen", rvalid, 1'b1);
        d    = rdata;
        resp = rresp;
        tick();
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [1:0]  rr;
        logic        stable;

        for (int i = 0; i < 16; i++) begin
            vec[i].addr      = 8'(i * 4);
            vec[i].wdata     = 32'hA5A5_0000 + 32'(i);
            vec[i].wstrb     = 4'hF;
            vec[i].exp_bresp = (i == 0) ? 2'b10 : 2'b00;
            vec[i].exp_rdata = (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i);
            vec[i].exp_rresp = 2'b00;
        end
        vec[16] = '{8'h0F, 32'h1122_3344, 4'b0011, 2'b00, 32'hA5A5_3344, 2'b00};
        vec[17] = '{8'h40, 32'hDEAD_BEEF, 4'hF,    2'b10, 32'h0,         2'b10};
        vec[18] = '{8'h3C, 32'h0,         4'h0,    2'b00, 32'hA5A5_000F, 2'b00};
        vec[19] = '{8'hFC, 32'h1,         4'hF,    2'b10, 32'h0,         2'b10};
        vec[20] = '{8'h01, 32'hFFFF_FFFF, 4'hF,    2'b10, 32'h0,         2'b00};

        rst_n   = 1'b0;
        awvalid = 1'b0;
        awaddr  = '0;
        wvalid  = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        bready  = 1'b1;
        arvalid = 1'b0;
        araddr  = '0;
        rready  = 1'b1;

        // Reset state
        #1;
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_rresp", rresp, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_reg_q_nonzero", |reg_q, 1'b0);
        repeat (3) tick();
        check("rst_awready", awready, 1'b0);
        check("rst_arready", arready, 1'b0);
        rst_n = 1'b1;
        check("post_rst_awready_before_clk", awready, 1'b0);
        tick();
        check("post_rst_awready", awready, 1'b1);
        check("post_rst_wready", wready, 1'b1);
        check("post_rst_arready", arready, 1'b1);

        // Table-driven write/read vectors
        for (int k = 0; k < NV; k++) begin
            axi_write(vec[k].addr, vec[k].wdata, vec[k].wstrb, resp);
            check($sformatf("v%0d_bresp", k), resp, vec[k].exp_bresp);
            axi_read(vec[k].addr, rd, rr);
            check($sformatf("v%0d_rdata", k), rd, vec[k].exp_rdata);
            check($sformatf("v%0d_rresp", k), rr, vec[k].exp_rresp);
            if (vec[k].exp_rresp == 2'b00)
                check($sformatf("v%0d_reg_q", k), reg_of(int'(vec[k].addr[5:2])), vec[k].exp_rdata);
        end
        for (int i = 0; i < 16; i++) begin
            check($sformatf("table_reg_q%0d", i), reg_of(i),
                  (i == 0) ? 32'h0 : (i == 3) ? 32'hA5A5_3344 : 32'hA5A5_0000 + 32'(i));
        end

        // W three cycles ahead of AW
        wdata  = 32'h1234_5678;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        check("early_w_wready", wready, 1'b1);
        tick();
        wvalid = 1'b0;
        check("early_w_wready_low", wready, 1'b0);
        tick();
        tick();
        check("early_w_no_bvalid", bvalid, 1'b0);
        check("early_w_awready", awready, 1'b1);
        awaddr  = 8'h08;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("early_w_bvalid", bvalid, 1'b1);
        check("early_w_bresp", bresp, 2'b00);
        check("early_w_reg2", reg_of(2), 32'h1234_5678);
        check("early_w_wready_bvalid", wready, 1'b0);
        tick();
        check("early_w_b_done", bvalid, 1'b0);
        check("early_w_awready_back", awready, 1'b1);
        check("early_w_wready_back", wready, 1'b1);

        // Byte strobes
        axi_write(8'h14, 32'hFFFF_FFFF, 4'hF, resp);
        axi_write(8'h14, 32'h0, 4'b0101, resp);
        check("strobe_bresp", resp, 2'b00);
        axi_read(8'h14, rd, rr);
        check("strobe_rdata", rd, 32'hFF00_FF00);

        // B channel stall: only the write side stops
        bready  = 1'b0;
        awaddr  = 8'h18;
        wdata   = 32'hCAFE_F00D;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awaddr  = 8'h1C;
        wdata   = 32'h0000_0077;
        stable  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (!(bvalid && bresp == 2'b00 && !awready && !wready)) stable = 1'b0;
            tick();
        end
        check("bstall_stable", stable, 1'b1);
        axi_read(8'h18, rd, rr);
        check("bstall_read_rdata", rd, 32'hCAFE_F00D);
        check("bstall_read_rresp", rr, 2'b00);
        check("bstall_bvalid_still", bvalid, 1'b1);
        check("bstall_awready_still", awready, 1'b0);
        bready  = 1'b1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        tick();
        check("bstall_release_bvalid", bvalid, 1'b0);
        check("bstall_release_awready", awready, 1'b1);
        check("bstall_release_wready", wready, 1'b1);
        check("bstall_reg7_untouched", reg_of(7), 32'hA5A5_0007);

        // R channel stall: only the read side stops
        rready  = 1'b0;
        araddr  = 8'h14;
        arvalid = 1'b1;
        tick();
        araddr  = 8'h40;
        stable  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (!(rvalid && rdata == 32'hFF00_FF00 && rresp == 2'b00 && !arready)) stable = 1'b0;
            tick();
        end
        check("rstall_stable", stable, 1'b1);
        arvalid = 1'b0;
        axi_write(8'h20, 32'h0BAD_CAFE, 4'hF, resp);
        check("rstall_write_bresp", resp, 2'b00);
        check("rstall_write_reg8", reg_of(8), 32'h0BAD_CAFE);
        rready = 1'b0;
        check("rstall_rvalid_still", rvalid, 1'b1);
        check("rstall_rdata_still", rdata, 32'hFF00_FF00);
        rready = 1'b1;
        tick();
        check("rstall_release_rvalid", rvalid, 1'b0);
        check("rstall_release_arready", arready, 1'b1);

        // Reset with AW held and a pending read response
        awaddr  = 8'h24;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("mid_rst_aw_held", awready, 1'b0);
        rready  = 1'b0;
        araddr  = 8'h24;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("mid_rst_rvalid_pending", rvalid, 1'b1);
        #2;
        rst_n  = 1'b0;
        wdata  = 32'h0000_0055;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        #1;
        check("mid_rst_rvalid", rvalid, 1'b0);
        check("mid_rst_bvalid", bvalid, 1'b0);
        check("mid_rst_awready", awready, 1'b0);
        check("mid_rst_arready", arready, 1'b0);
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_reg9", reg_of(9), 32'h0);
        rready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_wready_after", wready, 1'b1);
        tick();
        wvalid = 1'b0;
        tick();
        tick();
        check("mid_rst_aw_discarded", bvalid, 1'b0);
        check("mid_rst_reg9_after", reg_of(9), 32'h0);
        awaddr  = 8'h28;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("mid_rst_clean_bvalid", bvalid, 1'b1);
        check("mid_rst_clean_reg10", reg_of(10), 32'h0000_0055);
        tick();
        check("mid_rst_clean_b_done", bvalid, 1'b0);
        check("mid_rst_reg9_final", reg_of(9), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
